change_dispenser: RTL and testbench



---
 rtl/change_dispenser_pkg.sv | 25 ++
 rtl/change_dispenser_if.sv | 29 ++
 rtl/change_dispenser_coin_pick.sv | 47 ++++
 rtl/change_dispenser.sv | 141 ++++++++++++++
 tb/tb_change_dispenser.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/change_dispenser_pkg.sv
// Shared types for the change dispenser: coin encodings, coin values, FSM states.
package vm_pkg;

  localparam int AMT_W = 8;

  localparam int V_LO  = 1;
  localparam int V_MID = 2;
  localparam int V_HI  = 5;

  typedef enum logic [1:0] {
    COIN_NONE = 2'b00,
    COIN_LO   = 2'b01,
    COIN_MID  = 2'b10,
    COIN_HI   = 2'b11
  } coin_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_VEND,
    S_PAY,
    S_GAP,
    S_DONE
  } state_t;

endpackage

// File: rtl/change_dispenser_if.sv
// Command and coin-hopper signals between the control unit/hopper and the dispenser.
interface change_dispenser_if #(parameter int AMT_W = vm_pkg::AMT_W);

  logic             ldSelect;
  logic             refund;
  logic [AMT_W-1:0] payment;
  logic [AMT_W-1:0] price;
  logic [2:0]       hop_empty;
  logic             coin_ack;
  logic             coin_req;
  logic [1:0]       coin_type;
  logic             item_release;
  logic             busy;
  logic             done;
  logic             short;
  logic [AMT_W-1:0] owed;
  logic             err;

  modport slave (
    input  ldSelect, refund, payment, price, hop_empty, coin_ack,
    output coin_req, coin_type, item_release, busy, done, short, owed, err
  );

  modport master (
    output ldSelect, refund, payment, price, hop_empty, coin_ack,
    input  coin_req, coin_type, item_release, busy, done, short, owed, err
  );

endinterface

// File: rtl/change_dispenser_coin_pick.sv
// Greedy coin selector: largest non-empty coin whose value fits in the remainder.
module coin_pick
  import vm_pkg::*;
#(
  parameter int AMT_W = vm_pkg::AMT_W,
  parameter int V_LO  = vm_pkg::V_LO,
  parameter int V_MID = vm_pkg::V_MID,
  parameter int V_HI  = vm_pkg::V_HI
) (
  input  logic [AMT_W-1:0] remain,
  input  logic [2:0]       hop_empty,
  output coin_t            coin_type,
  output logic [AMT_W-1:0] value,
  output logic             none
);

  logic [AMT_W-1:0] vals [3];
  logic [2:0]       ok;

  assign vals[0] = AMT_W'(V_LO);
  assign vals[1] = AMT_W'(V_MID);
  assign vals[2] = AMT_W'(V_HI);

  for (genvar gi = 0; gi < 3; gi++) begin : g_ok
    assign ok[gi] = !hop_empty[gi] && (remain >= vals[gi]);
  end

  always_comb begin
    coin_type = COIN_NONE;
    value     = '0;
    none      = 1'b1;
    if (ok[2]) begin
      coin_type = COIN_HI;
      value     = vals[2];
      none      = 1'b0;
    end else if (ok[1]) begin
      coin_type = COIN_MID;
      value     = vals[1];
      none      = 1'b0;
    end else if (ok[0]) begin
      coin_type = COIN_LO;
      value     = vals[0];
      none      = 1'b0;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Vend/refund sequencer: releases the item, then pays change one coin per req/ack.
module change_dispenser
  import vm_pkg::*;
#(
  parameter int AMT_W = vm_pkg::AMT_W,
  parameter int V_LO  = vm_pkg::V_LO,
  parameter int V_MID = vm_pkg::V_MID,
  parameter int V_HI  = vm_pkg::V_HI
) (
  input  logic            clk,
  input  logic            rst,
  change_dispenser_if.slave bus
);

  state_t           state_reg, state_next;
  logic [AMT_W-1:0] remain_reg, remain_next;
  logic             held_reg, held_next;
  coin_t            hold_type_reg, hold_type_next;
  logic [AMT_W-1:0] hold_val_reg, hold_val_next;
  logic             short_reg, short_next;
  logic [AMT_W-1:0] owed_reg, owed_next;
  logic             err_reg, err_next;

  coin_t            pick_type;
  logic [AMT_W-1:0] pick_val;
  logic             pick_none;
  logic             req_comb;
  coin_t            type_comb;
  logic             strobe, accept, underpay;

  coin_pick #(
    .AMT_W (AMT_W),
    .V_LO  (V_LO),
    .V_MID (V_MID),
    .V_HI  (V_HI)
  ) u_pick (
    .remain    (remain_reg),
    .hop_empty (bus.hop_empty),
    .coin_type (pick_type),
    .value     (pick_val),
    .none      (pick_none)
  );

  assign strobe   = bus.ldSelect || bus.refund;
  assign accept   = (state_reg == S_IDLE) && strobe;
  assign underpay = bus.ldSelect && !bus.refund && (bus.payment < bus.price);

  always_comb begin
    state_next     = state_reg;
    remain_next    = remain_reg;
    held_next      = held_reg;
    hold_type_next = hold_type_reg;
    hold_val_next  = hold_val_reg;
    short_next     = short_reg;
    owed_next      = owed_reg;
    req_comb       = 1'b0;
    type_comb      = COIN_NONE;
    err_next       = (accept && underpay) || ((state_reg != S_IDLE) && strobe);

    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          short_next = 1'b0;
          owed_next  = '0;
          if (bus.refund || underpay) begin
            remain_next = bus.payment;
            state_next  = S_PAY;
          end else begin
            remain_next = bus.payment - bus.price;
            state_next  = S_VEND;
          end
        end
      end
      S_VEND: state_next = (remain_reg == '0) ? S_DONE : S_PAY;
      S_PAY: begin
        // The coin chosen on the first PAY cycle is latched so req/type stay stable until ack.
        if (held_reg) begin
          req_comb  = 1'b1;
          type_comb = hold_type_reg;
          if (bus.coin_ack) begin
            remain_next = remain_reg - hold_val_reg;
            held_next   = 1'b0;
            state_next  = S_GAP;
          end
        end else if (remain_reg == '0) begin
          state_next = S_DONE;
        end else if (pick_none) begin
          short_next = 1'b1;
          owed_next  = remain_reg;
          state_next = S_DONE;
        end else begin
          req_comb  = 1'b1;
          type_comb = pick_type;
          if (bus.coin_ack) begin
            remain_next = remain_reg - pick_val;
            state_next  = S_GAP;
          end else begin
            held_next      = 1'b1;
            hold_type_next = pick_type;
            hold_val_next  = pick_val;
          end
        end
      end
      S_GAP:   state_next = S_PAY;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= S_IDLE;
      remain_reg    <= '0;
      held_reg      <= 1'b0;
      hold_type_reg <= COIN_NONE;
      hold_val_reg  <= '0;
      short_reg     <= 1'b0;
      owed_reg      <= '0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      remain_reg    <= remain_next;
      held_reg      <= held_next;
      hold_type_reg <= hold_type_next;
      hold_val_reg  <= hold_val_next;
      short_reg     <= short_next;
      owed_reg      <= owed_next;
      err_reg       <= err_next;
    end
  end

  assign bus.coin_req     = req_comb;
  assign bus.coin_type    = type_comb;
  assign bus.item_release = (state_reg == S_VEND);
  assign bus.busy         = (state_reg != S_IDLE);
  assign bus.done         = (state_reg == S_DONE);
  assign bus.short        = short_reg;
  assign bus.owed         = owed_reg;
  assign bus.err          = err_reg;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench: hopper model with random ack latency and a greedy change reference.
module tb_change_dispenser;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  change_dispenser_if bus ();

  change_dispenser dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  string obs_coins;
  int    obs_items, obs_item_cyc, obs_errs, obs_first_req, obs_done, obs_done_cyc;
  int    obs_short, obs_owed, obs_busy_after;
  bit    obs_timeout, obs_unstable;

  string exp_coins;
  int    exp_items, exp_err, exp_short, exp_owed, exp_first_req;

  function automatic string code(input logic [1:0] t);
    case (t)
      2'b11:   return "H";
      2'b10:   return "M";
      2'b01:   return "L";
      default: return "?";
    endcase
  endfunction

  // Reference: greedy 50/20/10 sen payout from the amount owed, skipping empty tubes.
  task automatic model(input bit vend, input bit rfd, input int pay, input int pr,
                       input logic [2:0] he, input bit injected);
    int rem;
    exp_coins = "";
    exp_items = 0;
    exp_short = 0;
    exp_owed  = 0;
    exp_err   = injected ? 1 : 0;
    if (vend && !rfd && pay >= pr) begin
      rem       = pay - pr;
      exp_items = 1;
    end else begin
      rem = pay;
      if (vend && !rfd) exp_err++;
    end
    while (rem > 0) begin
      if (!he[2] && rem >= 5) begin
        rem -= 5; exp_coins = {exp_coins, "H"};
      end else if (!he[1] && rem >= 2) begin
        rem -= 2; exp_coins = {exp_coins, "M"};
      end else if (!he[0]) begin
        rem -= 1; exp_coins = {exp_coins, "L"};
      end else begin
        exp_short = 1; exp_owed = rem; rem = 0;
      end
    end
    exp_first_req = (exp_coins.len() == 0) ? -1 : (exp_items == 1 ? 2 : 1);
  endtask

  task automatic run_txn(input bit vend, input bit rfd, input logic [7:0] pay,
                         input logic [7:0] pr, input logic [2:0] he, input int lat,
                         input int inject_at);
    int cyc = 0;
    int wcnt = 0;
    bit held = 0;
    logic [1:0] held_type = 2'b00;
    obs_coins = ""; obs_items = 0; obs_item_cyc = -1; obs_errs = 0; obs_first_req = -1;
    obs_done = 0; obs_done_cyc = -1; obs_short = 0; obs_owed = 0; obs_busy_after = 1;
    obs_timeout = 0; obs_unstable = 0;
    @(negedge clk);
    bus.ldSelect = vend; bus.refund = rfd; bus.payment = pay; bus.price = pr;
    bus.hop_empty = he; bus.coin_ack = 1'b0;
    while (obs_done == 0 && !obs_timeout) begin
      @(negedge clk);
      cyc++;
      bus.ldSelect = 1'b0; bus.refund = 1'b0; bus.coin_ack = 1'b0;
      bus.payment = 8'($urandom_range(0, 255));
      bus.price   = 8'($urandom_range(0, 255));
      if (cyc == inject_at) bus.ldSelect = 1'b1;
      if (bus.item_release) begin
        obs_items++;
        if (obs_item_cyc < 0) obs_item_cyc = cyc;
      end
      if (bus.err) obs_errs++;
      if (bus.coin_req) begin
        if (obs_first_req < 0) obs_first_req = cyc;
        if (held && bus.coin_type !== held_type) obs_unstable = 1;
        held = 1; held_type = bus.coin_type; wcnt++;
        if (wcnt >= lat) begin
          bus.coin_ack = 1'b1;
          obs_coins = {obs_coins, code(bus.coin_type)};
          wcnt = 0; held = 0;
        end
      end else begin
        held = 0;
        if ($urandom_range(0, 3) == 0) bus.coin_ack = 1'b1;
      end
      if (bus.done) begin
        obs_done++; obs_done_cyc = cyc; obs_short = bus.short; obs_owed = bus.owed;
      end
      if (cyc >= 300) obs_timeout = 1;
    end
    @(negedge clk);
    bus.ldSelect = 1'b0; bus.coin_ack = 1'b0;
    obs_busy_after = bus.busy;
    if (bus.err) obs_errs++;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({bus.coin_req, bus.coin_type, bus.item_release, bus.busy, bus.done, bus.short,
         bus.owed, bus.err} !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got req=%b type=%b item=%b busy=%b done=%b short=%b owed=%0d err=%b, want all 0",
               bus.coin_req, bus.coin_type, bus.item_release, bus.busy, bus.done,
               bus.short, bus.owed, bus.err);
    end
    rst = 1'b1;
    $display("[TB] reset checked");
  endtask

  task automatic test_vend_single;
    run_txn(1, 0, 20, 15, 3'b000, 1, 0);
    n_tests++;
    if (obs_coins != "H" || obs_items != 1 || obs_item_cyc != 1 || obs_first_req != 2 ||
        obs_done != 1 || obs_short != 0 || obs_owed != 0 || obs_timeout) begin
      n_fail++;
      $display("FAIL vend_single: coins=%s items=%0d item_cyc=%0d first_req=%0d done=%0d short=%0d owed=%0d, want H 1 1 2 1 0 0",
               obs_coins, obs_items, obs_item_cyc, obs_first_req, obs_done, obs_short, obs_owed);
    end
    $display("[TB] vend 20/15 coins=%s", obs_coins);
  endtask

  task automatic test_vend_multi;
    run_txn(1, 0, 18, 10, 3'b000, 2, 0);
    n_tests++;
    if (obs_coins != "HML" || obs_items != 1 || obs_done != 1 || obs_unstable || obs_busy_after != 0) begin
      n_fail++;
      $display("FAIL vend_multi: coins=%s items=%0d done=%0d unstable=%0d busy_after=%0d, want HML 1 1 0 0",
               obs_coins, obs_items, obs_done, obs_unstable, obs_busy_after);
    end
    $display("[TB] vend 18/10 coins=%s", obs_coins);
  endtask

  task automatic test_refund_tube;
    run_txn(0, 1, 7, 0, 3'b100, 1, 0);
    n_tests++;
    if (obs_coins != "MMML" || obs_items != 0 || obs_first_req != 1 || obs_errs != 0) begin
      n_fail++;
      $display("FAIL refund_tube: coins=%s items=%0d first_req=%0d errs=%0d, want MMML 0 1 0",
               obs_coins, obs_items, obs_first_req, obs_errs);
    end
    $display("[TB] refund 7 hi-empty coins=%s", obs_coins);
  endtask

  task automatic test_underpay;
    run_txn(1, 0, 5, 10, 3'b000, 3, 0);
    n_tests++;
    if (obs_coins != "H" || obs_items != 0 || obs_errs != 1 || obs_first_req != 1) begin
      n_fail++;
      $display("FAIL underpay: coins=%s items=%0d errs=%0d first_req=%0d, want H 0 1 1",
               obs_coins, obs_items, obs_errs, obs_first_req);
    end
    $display("[TB] underpay 5/10 coins=%s errs=%0d", obs_coins, obs_errs);
  endtask

  task automatic test_short;
    run_txn(0, 1, 3, 0, 3'b011, 1, 0);
    n_tests++;
    if (obs_first_req != -1 || obs_done != 1 || obs_short != 1 || obs_owed != 3) begin
      n_fail++;
      $display("FAIL short_pay: first_req=%0d done=%0d short=%0d owed=%0d, want -1 1 1 3",
               obs_first_req, obs_done, obs_short, obs_owed);
    end
    @(negedge clk);
    n_tests++;
    if (bus.owed !== 8'd3 || bus.short !== 1'b1) begin
      n_fail++;
      $display("FAIL owed_held: owed=%0d short=%b, want 3 1", bus.owed, bus.short);
    end
    $display("[TB] refund 3 lo/mid-empty short=%0d owed=%0d", obs_short, obs_owed);
  endtask

  task automatic test_zero_change;
    run_txn(1, 0, 10, 10, 3'b000, 1, 0);
    n_tests++;
    if (obs_done_cyc != 2 || obs_first_req != -1 || obs_items != 1 || obs_short != 0 || obs_owed != 0) begin
      n_fail++;
      $display("FAIL zero_change: done_cyc=%0d first_req=%0d items=%0d short=%0d owed=%0d, want 2 -1 1 0 0",
               obs_done_cyc, obs_first_req, obs_items, obs_short, obs_owed);
    end
    $display("[TB] vend 10/10 done_cyc=%0d", obs_done_cyc);
  endtask

  task automatic test_back_to_back;
    run_txn(1, 0, 18, 10, 3'b000, 2, 3);
    n_tests++;
    if (obs_coins != "HML" || obs_errs != 1 || obs_items != 1) begin
      n_fail++;
      $display("FAIL dropped_cmd: coins=%s errs=%0d items=%0d, want HML 1 1",
               obs_coins, obs_errs, obs_items);
    end
    $display("[TB] strobe during payout errs=%0d coins=%s", obs_errs, obs_coins);
    run_txn(1, 1, 20, 15, 3'b000, 1, 0);
    n_tests++;
    if (obs_coins != "HHHH" || obs_items != 0 || obs_errs != 0) begin
      n_fail++;
      $display("FAIL refund_wins: coins=%s items=%0d errs=%0d, want HHHH 0 0",
               obs_coins, obs_items, obs_errs);
    end
    $display("[TB] vend+refund together coins=%s", obs_coins);
  endtask

  task automatic test_reset_mid;
    bit saw_done = 0;
    @(negedge clk);
    bus.refund = 1'b1; bus.payment = 8'd7; bus.hop_empty = 3'b000;
    @(negedge clk);
    bus.refund = 1'b0;
    n_tests++;
    if (bus.coin_req !== 1'b1 || bus.coin_type !== 2'b11) begin
      n_fail++;
      $display("FAIL rstmid_first_req: req=%b type=%b, want 1 11", bus.coin_req, bus.coin_type);
    end
    bus.coin_ack = 1'b1;
    @(negedge clk);
    bus.coin_ack = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.coin_req !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_drop: req=%b busy=%b, want 0 0", bus.coin_req, bus.busy);
    end
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.done || bus.coin_req) saw_done = 1;
    end
    n_tests++;
    if (saw_done) begin
      n_fail++;
      $display("FAIL rstmid_quiet: got done/req activity after reset, want none");
    end
    $display("[TB] reset mid-payout checked");
  endtask

  task automatic test_random;
    for (int t = 0; t < 30; t++) begin
      bit vend, rfd;
      int pay, pr, lat, inj;
      logic [2:0] he;
      vend = 1'($urandom_range(0, 1));
      rfd  = vend ? ($urandom_range(0, 4) == 0) : 1'b1;
      pay  = $urandom_range(0, 40);
      pr   = $urandom_range(0, 40);
      he   = 3'($urandom_range(0, 7));
      lat  = $urandom_range(1, 3);
      inj  = $urandom_range(0, 2);
      model(vend, rfd, pay, pr, he, inj != 0);
      run_txn(vend, rfd, 8'(pay), 8'(pr), he, lat, inj);
      n_tests++;
      if (obs_coins != exp_coins || obs_items != exp_items || obs_errs != exp_err ||
          obs_done != 1 || obs_short != exp_short || obs_owed != exp_owed ||
          obs_first_req != exp_first_req || obs_unstable || obs_busy_after != 0 || obs_timeout) begin
        n_fail++;
        $display("FAIL random_%0d: coins=%s items=%0d errs=%0d short=%0d owed=%0d first=%0d unst=%0d to=%0d; want coins=%s items=%0d errs=%0d short=%0d owed=%0d first=%0d",
                 t, obs_coins, obs_items, obs_errs, obs_short, obs_owed, obs_first_req,
                 obs_unstable, obs_timeout, exp_coins, exp_items, exp_err, exp_short,
                 exp_owed, exp_first_req);
      end
      $display("[TB] rand %0d vend=%0d rfd=%0d pay=%0d price=%0d he=%b coins=%s",
               t, vend, rfd, pay, pr, he, obs_coins);
    end
  endtask

  initial begin
    bus.ldSelect = 1'b0; bus.refund = 1'b0; bus.payment = '0; bus.price = '0;
    bus.hop_empty = 3'b000; bus.coin_ack = 1'b0;
    test_reset();
    test_vend_single();
    test_vend_multi();
    test_refund_tube();
    test_underpay();
    test_short();
    test_zero_change();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
